mux_arbiter: RTL and testbench

- Round-robin controller that shares the 2:1 select datapath (`sel` → mux `s`) between two requesters, X and Y.
- Grants one requester at a time and holds the grant for a whole burst, closed by `last`.
- Registers the selected data into a one-entry output stage with a valid/ready handshake toward the sink.
- Sits directly in front of the mux and owns its select line; the mux itself stays combinational.

---
 rtl/mux_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin owner of a 2:1 mux select line shared by two
// requesters (X and Y). A grant is held for a whole burst (closed by last)
// and beats are registered into a one-entry output stage with valid/ready.
// Optional feature: define MUX_ARB_BURST_LIMIT_EN to force rotation after
// BURST_MAX beats when the other requester is waiting.
//
// Handshake: a beat moves from a requester when gnt_* & req_* are both high
// at a rising edge; a beat leaves m when m_valid & m_ready are both high at a
// rising edge. gnt_* already includes output-stage space, so it acts as the
// requester's ready.
module mux_arbiter #(
  parameter int W         = 2,
  parameter int BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_x,
  input  logic [W-1:0] data_x,
  input  logic         last_x,
  output logic         gnt_x,
  input  logic         req_y,
  input  logic [W-1:0] data_y,
  input  logic         last_y,
  output logic         gnt_y,
  output logic         sel,
  output logic [W-1:0] m,
  output logic         m_valid,
  input  logic         m_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_X = 2'd1,
    GRANT_Y = 2'd2
  } state_e;

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
`endif

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;      // last owner released: 0 = X, 1 = Y
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;      // accepted beats in current grant
  logic [W-1:0]  m_q, m_d;
  logic          m_valid_q, m_valid_d;

  logic space;
  logic acc_x, acc_y;
  logic release_own;
  logic lim_hit;

  assign space   = !m_valid_q | m_ready;
  assign gnt_x   = (state_q == GRANT_X) & space;
  assign gnt_y   = (state_q == GRANT_Y) & space;
  assign acc_x   = gnt_x & req_x;
  assign acc_y   = gnt_y & req_y;
  assign sel     = sel_q;
  assign m       = m_q;
  assign m_valid = m_valid_q;

  // Next-state, round-robin pointer, select and beat counter.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    release_own = 1'b0;
    lim_hit     = 1'b0;
    case (state_q)
      IDLE: begin
        // ptr_q == 1 means Y was served last, so X wins a tie.
        if (req_x && (!req_y || ptr_q)) state_d = GRANT_X;
        else if (req_y)                 state_d = GRANT_Y;
      end
      GRANT_X: begin
`ifdef MUX_ARB_BURST_LIMIT_EN
        lim_hit = acc_x & req_y & (cnt_q >= CNT_LAST);
`endif
        release_own = !req_x | (acc_x & last_x) | lim_hit;
        if (release_own) begin
          ptr_d   = 1'b0;
          state_d = req_y ? GRANT_Y : IDLE;
        end
      end
      GRANT_Y: begin
`ifdef MUX_ARB_BURST_LIMIT_EN
        lim_hit = acc_y & req_x & (cnt_q >= CNT_LAST);
`endif
        release_own = !req_y | (acc_y & last_y) | lim_hit;
        if (release_own) begin
          ptr_d   = 1'b1;
          state_d = req_x ? GRANT_X : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter clears on release and saturates at BURST_MAX otherwise.
    if (release_own)                            cnt_d = '0;
    else if ((acc_x | acc_y) && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;

    // Select follows the owner; it holds its last value through IDLE.
    case (state_d)
      GRANT_X: sel_d = 1'b0;
      GRANT_Y: sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  // One-entry output stage: accept replaces (and drains) the held beat.
  always_comb begin
    m_d       = m_q;
    m_valid_d = m_valid_q;
    if (acc_x | acc_y) begin
      m_d       = sel_q ? data_y : data_x;
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      m_q       <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed timing steps followed by randomized
// bursts scored against per-requester expected queues.
module tb_mux_arbiter;
  localparam int W = 8;
  localparam int BURST_MAX = 4;

  typedef struct packed { logic [W-1:0] d; logic l; } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_x = 1'b0, last_x = 1'b0, req_y = 1'b0, last_y = 1'b0;
  logic [W-1:0] data_x = '0, data_y = '0;
  logic         gnt_x, gnt_y, sel, m_valid;
  logic [W-1:0] m;
  logic         m_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t        x_q[$], y_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_x_q[$], exp_y_q[$];
  logic [W-1:0] exp_q[$];
  int           lx_q[$], ly_q[$];

  mux_arbiter #(.W(W), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .req_x(req_x), .data_x(data_x), .last_x(last_x), .gnt_x(gnt_x),
    .req_y(req_y), .data_y(data_y), .last_y(last_y), .gnt_y(gnt_y),
    .sel(sel), .m(m), .m_valid(m_valid), .m_ready(m_ready)
  );

  // Clock: rising edges at 5 + 10k, falling edges at 10k.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_x = 1'b0; req_y = 1'b0; last_x = 1'b0; last_y = 1'b0;
    data_x = '0; data_y = '0; m_ready = 1'b1;
    repeat (2) nxt();
    rst = 1'b0;
  endtask

  // Drives both requesters from x_q / y_q and records every beat leaving m.
  task automatic run_traffic(input int max_cyc, input bit rnd);
    int x_gap, y_gap, cyc;
    bit ax, ay;
    x_gap = 0; y_gap = 0; cyc = 0;
    got_q.delete();
    while ((x_q.size() > 0 || y_q.size() > 0 || m_valid === 1'b1) && cyc < max_cyc) begin
      req_x = (x_q.size() > 0) && (x_gap == 0);
      if (x_q.size() > 0) begin data_x = x_q[0].d; last_x = x_q[0].l; end
      req_y = (y_q.size() > 0) && (y_gap == 0);
      if (y_q.size() > 0) begin data_y = y_q[0].d; last_y = y_q[0].l; end
      m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #3;
      ax = gnt_x & req_x;
      ay = gnt_y & req_y;
      if (m_valid && m_ready) got_q.push_back(m);
      nxt();
      if (ax) begin
        if (x_q[0].l && rnd) x_gap = $urandom_range(0, 2);
        void'(x_q.pop_front());
      end else if (x_gap > 0) x_gap--;
      if (ay) begin
        if (y_q[0].l && rnd) y_gap = $urandom_range(0, 2);
        void'(y_q.pop_front());
      end else if (y_gap > 0) y_gap--;
      cyc++;
    end
    chk("traffic_done_in_budget", 32'(cyc < max_cyc), 32'd1);
    req_x = 1'b0; req_y = 1'b0; last_x = 1'b0; last_y = 1'b0; m_ready = 1'b1;
  endtask

  task automatic add_burst(input bit src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {src, 7'($urandom_range(0, 127))};
      b.l = (i == len - 1);
      if (src) begin y_q.push_back(b); exp_y_q.push_back(b.d); end
      else     begin x_q.push_back(b); exp_x_q.push_back(b.d); end
    end
    if (src) ly_q.push_back(len); else lx_q.push_back(len);
  endtask

  initial begin
    beat_t        b;
    logic [W-1:0] e;
    logic         s, cur_src;
    int           left;

    // ---- Reset values and a single 3-beat X burst ----
    do_reset();
    chk("rst_m", m, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_gnt_x", gnt_x, 0);
    chk("rst_gnt_y", gnt_y, 0);
    req_x = 1'b1; data_x = 8'd1; last_x = 1'b0;   // cycle N
    nxt();
    chk("t1_gnt_x_n1", gnt_x, 1);
    chk("t1_sel_n1", sel, 0);
    nxt();
    chk("t1_m_n2", m, 1);
    chk("t1_mv_n2", m_valid, 1);
    data_x = 8'd2;
    nxt();
    chk("t1_m_n3", m, 2);
    data_x = 8'd3; last_x = 1'b1;
    nxt();
    chk("t1_m_n4", m, 3);
    chk("t1_idle_gnt_x", gnt_x, 0);
    chk("t1_sel_idle", sel, 0);
    req_x = 1'b0; last_x = 1'b0;
    nxt();
    chk("t1_drained", m_valid, 0);

    // ---- Tie after reset, handover, next tie ----
    do_reset();
    req_x = 1'b1; data_x = 8'd5; last_x = 1'b1;
    req_y = 1'b1; data_y = 8'h86; last_y = 1'b0;
    nxt();
    chk("t2_tie_gnt_x", gnt_x, 1);
    chk("t2_tie_gnt_y", gnt_y, 0);
    nxt();
    req_x = 1'b0; last_x = 1'b0;
    chk("t2_handover_gnt_y", gnt_y, 1);
    chk("t2_handover_sel", sel, 1);
    chk("t2_m_x", m, 5);
    nxt();
    chk("t2_m_y0", m, 8'h86);
    data_y = 8'h87; last_y = 1'b1;
    nxt();
    chk("t2_m_y1", m, 8'h87);
    chk("t2_sel_hold_idle", sel, 1);
    chk("t2_idle_gnt_y", gnt_y, 0);
    req_y = 1'b0; last_y = 1'b0;
    nxt();
    req_x = 1'b1; data_x = 8'd8; last_x = 1'b1;
    req_y = 1'b1; data_y = 8'h89; last_y = 1'b1;
    nxt();
    chk("t2_tie2_gnt_x", gnt_x, 1);
    chk("t2_tie2_sel", sel, 0);
    nxt();
    req_x = 1'b0; last_x = 1'b0;
    chk("t2_tie2_then_y", gnt_y, 1);
    nxt();
    req_y = 1'b0; last_y = 1'b0;
    chk("t2_m_tie2_y", m, 8'h89);
    nxt();

    // ---- Sink stall for three cycles ----
    do_reset();
    req_x = 1'b1; data_x = 8'd1; last_x = 1'b0;
    nxt();
    chk("t3_gnt_x", gnt_x, 1);
    nxt();
    chk("t3_m_first", m, 1);
    data_x = 8'd2; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("t3_stall_gnt_x", gnt_x, 0);
      chk("t3_stall_m", m, 1);
      chk("t3_stall_mv", m_valid, 1);
    end
    m_ready = 1'b1;
    #1;
    chk("t3_resume_gnt_x", gnt_x, 1);
    nxt();
    chk("t3_m_second", m, 2);
    chk("t3_mv_second", m_valid, 1);
    data_x = 8'd3; last_x = 1'b1;
    nxt();
    chk("t3_m_third", m, 3);
    req_x = 1'b0; last_x = 1'b0;
    nxt();
    chk("t3_drained", m_valid, 0);

    // ---- Y drops req mid-burst while X waits ----
    do_reset();
    req_y = 1'b1; data_y = 8'h84; last_y = 1'b0;
    nxt();
    chk("t4_gnt_y", gnt_y, 1);
    req_x = 1'b1; data_x = 8'd10; last_x = 1'b1;
    nxt();
    chk("t4_m_y", m, 8'h84);
    req_y = 1'b0;
    nxt();
    chk("t4_gnt_x_after_drop", gnt_x, 1);
    chk("t4_gnt_y_after_drop", gnt_y, 0);
    chk("t4_sel_after_drop", sel, 0);
    chk("t4_no_beat_on_drop", m_valid, 0);
    nxt();
    chk("t4_m_x", m, 10);
    req_x = 1'b0; last_x = 1'b0;
    nxt();

    // ---- 6-beat X burst against a waiting 2-beat Y burst ----
    do_reset();
    x_q.delete(); y_q.delete();
    for (int i = 1; i <= 6; i++) begin
      b.d = W'(i); b.l = (i == 6); x_q.push_back(b);
    end
    for (int i = 1; i <= 2; i++) begin
      b.d = W'(8'h80 + i); b.l = (i == 2); y_q.push_back(b);
    end
    exp_q.delete();
`ifdef MUX_ARB_BURST_LIMIT_EN
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'h81, 8'h82, 8'd5, 8'd6};
`else
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'h81, 8'h82};
`endif
    run_traffic(200, 1'b0);
    chk("t5_beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("t5_order", got_q[i], exp_q[i]);

    // ---- Randomized bursts with random sink stalls ----
    do_reset();
    x_q.delete(); y_q.delete();
    exp_x_q.delete(); exp_y_q.delete(); lx_q.delete(); ly_q.delete();
    for (int i = 0; i < 12; i++) begin
      add_burst(1'b0, $urandom_range(1, 6));
      add_burst(1'b1, $urandom_range(1, 6));
    end
    run_traffic(5000, 1'b1);
    cur_src = 1'b0; left = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      s = got_q[i][W-1];
`ifndef MUX_ARB_BURST_LIMIT_EN
      if (left > 0) chk("rnd_burst_contiguous", s, cur_src);
      if (left == 0) begin
        cur_src = s;
        if (s && ly_q.size() > 0)       left = ly_q.pop_front();
        else if (!s && lx_q.size() > 0) left = lx_q.pop_front();
      end
      if (left > 0) left--;
`endif
      if (s) begin
        chk("rnd_y_expected", 32'(exp_y_q.size() > 0), 32'd1);
        e = (exp_y_q.size() > 0) ? exp_y_q.pop_front() : '0;
      end else begin
        chk("rnd_x_expected", 32'(exp_x_q.size() > 0), 32'd1);
        e = (exp_x_q.size() > 0) ? exp_x_q.pop_front() : '0;
      end
      chk("rnd_beat", got_q[i], e);
    end
    chk("rnd_x_all_delivered", exp_x_q.size(), 0);
    chk("rnd_y_all_delivered", exp_y_q.size(), 0);

    // ---- Reset mid-burst with a buffered beat ----
    do_reset();
    req_y = 1'b1; data_y = 8'h83; last_y = 1'b0;
    nxt();
    nxt();
    chk("t6_pre_mv", m_valid, 1);
    chk("t6_pre_sel", sel, 1);
    rst = 1'b1;
    nxt();
    chk("t6_rst_mv", m_valid, 0);
    chk("t6_rst_m", m, 0);
    chk("t6_rst_sel", sel, 0);
    chk("t6_rst_gnt_x", gnt_x, 0);
    chk("t6_rst_gnt_y", gnt_y, 0);
    rst = 1'b0; req_y = 1'b0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
